// File: rtl/fetch_unit.sv
// Program counter / fetch stage with start-done handshake and a loadable branch-target LUT.
// Optional build macro FETCH_RELATIVE_BRANCH_EN makes LUT entries PC-relative offsets instead of absolute targets.
module fetch_unit #(
  parameter int unsigned PC_W   = 10,
  parameter int unsigned LUT_AW = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              Reset_n,
  input  logic              start,
  input  logic [8:0]        inst,
  input  logic              jump_en,
  input  logic              branch_en,
  input  logic              halt,
  input  logic              lut_we,
  input  logic [LUT_AW-1:0] lut_waddr,
  input  logic [PC_W-1:0]   lut_wdata,
  output logic [PC_W-1:0]   pc,
  output logic              running,
  output logic              done,
  output logic [CNT_W-1:0]  cycle_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state;

  logic [PC_W-1:0]   lut [0:(1<<LUT_AW)-1];
  logic [LUT_AW-1:0] lut_idx;
  logic [PC_W-1:0]   next_tgt;
  logic              unused_inst_bits;

  assign lut_idx          = inst[LUT_AW-1:0];
  assign unused_inst_bits = ^inst[8:LUT_AW];

  // No reset on the table: contents are software-loaded; a same-cycle write is seen only next cycle.
  always_ff @(posedge CLK) begin
    if (lut_we) lut[lut_waddr] <= lut_wdata;
  end

  always_comb begin
`ifdef FETCH_RELATIVE_BRANCH_EN
    next_tgt = pc + lut[lut_idx];
`else
    next_tgt = lut[lut_idx];
`endif
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= S_IDLE;
      pc        <= '0;
      running   <= 1'b0;
      done      <= 1'b0;
      cycle_cnt <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state     <= S_RUN;
            pc        <= '0;
            cycle_cnt <= '0;
            running   <= 1'b1;
            done      <= 1'b0;
          end
        end
        S_RUN: begin
          if (cycle_cnt != '1) cycle_cnt <= cycle_cnt + 1'b1;
          if (halt) begin
            state   <= S_DONE;
            running <= 1'b0;
            done    <= 1'b1;
          end else if (jump_en || branch_en) begin
            pc <= next_tgt;
          end else if (pc == '1) begin
            state   <= S_DONE;
            running <= 1'b0;
            done    <= 1'b1;
          end else begin
            pc <= pc + 1'b1;
          end
        end
        default: begin
          state   <= S_IDLE;
          running <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: vector table plus multi-cycle corner sequences, scoreboarded.
`timescale 1ns/1ps
module tb_fetch_unit;

  logic       CLK = 1'b0;
  logic       Reset_n = 1'b0;
  logic       start = 1'b0;
  logic [8:0] inst = '0;
  logic       jump_en = 1'b0;
  logic       branch_en = 1'b0;
  logic       halt = 1'b0;
  logic       lut_we = 1'b0;
  logic [4:0] lut_waddr = '0;
  logic [9:0] lut_wdata = '0;
  logic [9:0] pc;
  logic       running;
  logic       done;
  logic [15:0] cycle_cnt;

  fetch_unit #(.PC_W(10), .LUT_AW(5), .CNT_W(16)) dut (
    .CLK(CLK), .Reset_n(Reset_n), .start(start), .inst(inst),
    .jump_en(jump_en), .branch_en(branch_en), .halt(halt),
    .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
    .pc(pc), .running(running), .done(done), .cycle_cnt(cycle_cnt)
  );

  always #5 CLK = ~CLK;

`ifdef FETCH_RELATIVE_BRANCH_EN
  localparam int J1 = 47;   // pc 7 + 40
  localparam int R1 = 100;  // pc 0 + 100
  localparam int R2 = 300;  // pc 100 + 200
  localparam int B1 = 340;  // pc 300 + 40
`else
  localparam int J1 = 40;
  localparam int R1 = 100;
  localparam int R2 = 200;
  localparam int B1 = 40;
`endif

  typedef struct {
    logic        st, jm, br, ht;
    logic [8:0]  inst;
    logic        we;
    logic [4:0]  wa;
    logic [9:0]  wd;
    logic [9:0]  pc;
    logic        run, dn;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int n_vec = 0;
  int n_miss = 0;

  function automatic vec_t mk(int st, int jm, int br, int ht, int in, int we, int wa, int wd,
                              int epc, int erun, int edn, int ecnt);
    vec_t v;
    v.st = 1'(st); v.jm = 1'(jm); v.br = 1'(br); v.ht = 1'(ht);
    v.inst = 9'(in); v.we = 1'(we); v.wa = 5'(wa); v.wd = 10'(wd);
    v.pc = 10'(epc); v.run = 1'(erun); v.dn = 1'(edn); v.cnt = 16'(ecnt);
    return v;
  endfunction

  task automatic compare(input string tag, input vec_t e);
    n_vec++;
    if (pc !== e.pc || running !== e.run || done !== e.dn || cycle_cnt !== e.cnt) begin
      n_miss++;
      $display("FAIL %s: got pc=%0d running=%b done=%b cnt=%0d, expected pc=%0d running=%b done=%b cnt=%0d",
               tag, pc, running, done, cycle_cnt, e.pc, e.run, e.dn, e.cnt);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    vec_t e;
    @(negedge CLK);
    start = v.st; jump_en = v.jm; branch_en = v.br; halt = v.ht;
    inst = v.inst; lut_we = v.we; lut_waddr = v.wa; lut_wdata = v.wd;
    sb.push_back(v);
    @(posedge CLK);
    #1;
    if (sb.size() == 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL %s: scoreboard empty, expected an entry", tag);
    end else begin
      e = sb.pop_front();
      compare(tag, e);
    end
    start = 1'b0; jump_en = 1'b0; branch_en = 1'b0; halt = 1'b0;
    lut_we = 1'b0; inst = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss + 1);
    $fatal(1);
  end

  initial begin
    // Directed table: LUT load, basic stepping, halt, ignored controls, jump, branch, same-cycle LUT write.
    tbl.push_back(mk(0,0,0,0, 0, 1,5,40,  0,0,0,0));
    tbl.push_back(mk(0,0,0,0, 0, 1,3,100, 0,0,0,0));
    tbl.push_back(mk(0,1,0,0, 5, 0,0,0,   0,0,0,0));
    tbl.push_back(mk(1,0,0,0, 0, 0,0,0,   0,1,0,0));
    for (int i = 1; i <= 3; i++) tbl.push_back(mk(0,0,0,0, 0, 0,0,0, i,1,0,i));
    tbl.push_back(mk(0,0,0,1, 0, 0,0,0,   3,0,1,4));
    tbl.push_back(mk(0,1,0,0, 5, 0,0,0,   3,0,1,4));
    tbl.push_back(mk(1,0,0,0, 0, 0,0,0,   0,1,0,0));
    for (int i = 1; i <= 7; i++) tbl.push_back(mk(0,0,0,0, 0, 0,0,0, i,1,0,i));
    tbl.push_back(mk(0,1,0,0, 5, 0,0,0,   J1,1,0,8));
    tbl.push_back(mk(0,0,0,0, 0, 0,0,0,   J1+1,1,0,9));
    tbl.push_back(mk(1,0,0,0, 0, 0,0,0,   J1+2,1,0,10));
    tbl.push_back(mk(1,1,0,1, 5, 0,0,0,   J1+2,0,1,11));
    tbl.push_back(mk(1,0,0,0, 0, 0,0,0,   0,1,0,0));
    tbl.push_back(mk(0,1,0,0, 3, 1,3,200, R1,1,0,1));
    tbl.push_back(mk(0,1,0,0, 3, 0,0,0,   R2,1,0,2));
    tbl.push_back(mk(0,0,1,0, 5, 0,0,0,   B1,1,0,3));
    tbl.push_back(mk(0,0,0,1, 0, 0,0,0,   B1,0,1,4));

    // Reset values while reset is held
    #2;
    compare("reset_values", mk(0,0,0,0,0,0,0,0, 0,0,0,0));
    @(negedge CLK);
    @(negedge CLK);
    Reset_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("tbl%0d", i));

    // Run off the end of the address space: no wrap, DONE, then restart.
    apply(mk(1,0,0,0, 0, 0,0,0, 0,1,0,0), "end_start");
    for (int i = 1; i <= 1023; i++) apply(mk(0,0,0,0, 0, 0,0,0, i,1,0,i), $sformatf("end_step%0d", i));
    apply(mk(0,0,0,0, 0, 0,0,0, 1023,0,1,1024), "end_done");
    apply(mk(0,0,0,0, 0, 0,0,0, 1023,0,1,1024), "end_hold");
    apply(mk(1,0,0,0, 0, 0,0,0, 0,1,0,0), "end_restart");

    // Asynchronous reset mid-run at pc 20.
    for (int i = 1; i <= 20; i++) apply(mk(0,0,0,0, 0, 0,0,0, i,1,0,i), $sformatf("rst_step%0d", i));
    @(negedge CLK);
    #1 Reset_n = 1'b0;
    #1 compare("async_reset", mk(0,0,0,0,0,0,0,0, 0,0,0,0));
    @(negedge CLK);
    Reset_n = 1'b1;
    for (int i = 0; i < 3; i++) apply(mk(0,0,0,0, 0, 0,0,0, 0,0,0,0), $sformatf("post_rst_idle%0d", i));
    apply(mk(1,0,0,0, 0, 0,0,0, 0,1,0,0), "post_rst_start");
    apply(mk(0,0,0,0, 0, 0,0,0, 1,1,0,1), "post_rst_step");

`ifdef FETCH_RELATIVE_BRANCH_EN
    // Negative offset: lut[2] = -3, branch at pc 10 lands on 7.
    apply(mk(0,0,0,0, 0, 1,2,10'h3FD, 2,1,0,2), "rel_load");
    for (int i = 3; i <= 10; i++) apply(mk(0,0,0,0, 0, 0,0,0, i,1,0,i), $sformatf("rel_step%0d", i));
    apply(mk(0,0,1,0, 2, 0,0,0, 7,1,0,11), "rel_branch_back");
    apply(mk(0,0,0,0, 0, 0,0,0, 8,1,0,12), "rel_after");
`endif

    if (sb.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
